// File: rtl/sun_sar_pkg.sv
// Shared types and helpers for the SUN_TRB SAR sequencer.
//   state_e   : sequencer states
//   cnt_width : width of the shared sample/settle/timeout counter
package sun_sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    COMPARE,
    FINISH
  } state_e;

  // Counter holds at most max(...)-1, so clog2(max) bits suffice; never 0 wide.
  function automatic int cnt_width(input int nsamp, input int nset, input int ntmo);
    int m;
    m = nsamp;
    if (nset > m) m = nset;
    if (ntmo > m) m = ntmo;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sun_sar_cnt.sv
// Loadable down-counter with zero flag, shared by the sample, settle and
// compare-timeout phases.
//   clk_i/rst_i : clock, async active-high reset
//   load_i/val_i: load val_i (wins over dec_i)
//   dec_i       : decrement, saturating at zero
//   zero_o      : count is zero
module sun_sar_cnt #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sun_sar_ctrl.sv
// SAR conversion sequencer: tracks (SMPL), then binary-searches the CDAC
// (DAC) one bit at a time using the clocked comparator (CMP_EN/CMP_RDY/CMP_OUT).
//   CK/RST          : clock, async active-high reset
//   START/CONT      : conversion request (IDLE only) / continuous re-sample
//   CMP_RDY/CMP_OUT : comparator decision valid / input above DAC level
//   SMPL, DAC, CMP_EN : analog drives
//   DOUT/DONE       : completed code / one-cycle done pulse
//   BUSY/TMO        : not IDLE / sticky compare-timeout flag
// All outputs come straight from flops.
module sun_sar_ctrl
  import sun_sar_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int NSAMP = 4,
  parameter int NSET  = 1,
  parameter int NTMO  = 7
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  input  logic             CMP_RDY,
  input  logic             CMP_OUT,
  output logic             SMPL,
  output logic [NBITS-1:0] DAC,
  output logic             CMP_EN,
  output logic [NBITS-1:0] DOUT,
  output logic             DONE,
  output logic             BUSY,
  output logic             TMO
);

  localparam int CW = cnt_width(NSAMP, NSET, NTMO);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  state_e           state_q, state_d;
  logic             smpl_q, smpl_d, cmp_en_q, cmp_en_d;
  logic             done_q, done_d, busy_q, busy_d, tmo_q, tmo_d;
  logic [NBITS-1:0] dac_q, dac_d, dout_q, dout_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_val;

  sun_sar_cnt #(.W(CW)) u_cnt (
    .clk_i  (CK),
    .rst_i  (RST),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    smpl_d   = smpl_q;
    dac_d    = dac_q;
    cmp_en_d = cmp_en_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    tmo_d    = tmo_q;
    bit_d    = bit_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      IDLE: begin
        dac_d = '0;
        if (START) begin
          state_d  = SAMPLE;
          smpl_d   = 1'b1;
          tmo_d    = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CW'(NSAMP - 1);
        end
      end
      SAMPLE: begin
        if (cnt_zero) begin
          state_d          = SETTLE;
          smpl_d           = 1'b0;
          dac_d            = '0;
          dac_d[NBITS-1]   = 1'b1;
          bit_d            = BW'(NBITS - 1);
          cnt_load         = 1'b1;
          cnt_val          = CW'(NSET - 1);
        end else cnt_dec = 1'b1;
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d  = COMPARE;
          cmp_en_d = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CW'(NTMO - 1);
        end else cnt_dec = 1'b1;
      end
      COMPARE: begin
        // A decision on the last allowed cycle beats the timeout.
        if (CMP_RDY || cnt_zero) begin
          dac_d[bit_q] = CMP_RDY & CMP_OUT;
          if (!CMP_RDY) tmo_d = 1'b1;
          cmp_en_d = 1'b0;
          if (bit_q != '0) begin
            dac_d[bit_q - BW'(1)] = 1'b1;
            bit_d    = bit_q - BW'(1);
            state_d  = SETTLE;
            cnt_load = 1'b1;
            cnt_val  = CW'(NSET - 1);
          end else begin
            // Publish the code on FINISH entry so DONE/DOUT are valid in FINISH.
            state_d = FINISH;
            dout_d  = dac_d;
            done_d  = 1'b1;
          end
        end else cnt_dec = 1'b1;
      end
      FINISH: begin
        dac_d = '0;
        if (CONT) begin
          state_d  = SAMPLE;
          smpl_d   = 1'b1;
          tmo_d    = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CW'(NSAMP - 1);
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      smpl_q   <= 1'b0;
      dac_q    <= '0;
      cmp_en_q <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      smpl_q   <= smpl_d;
      dac_q    <= dac_d;
      cmp_en_q <= cmp_en_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      bit_q    <= bit_d;
    end
  end

  assign SMPL   = smpl_q;
  assign DAC    = dac_q;
  assign CMP_EN = cmp_en_q;
  assign DOUT   = dout_q;
  assign DONE   = done_q;
  assign BUSY   = busy_q;
  assign TMO    = tmo_q;

endmodule

// File: tb/tb_sun_sar_ctrl.sv
module tb_sun_sar_ctrl;
  localparam int NBITS = 8;
  localparam int NSAMP = 4;
  localparam int NSET  = 1;
  localparam int NTMO  = 7;

  logic             CK = 1'b0, RST = 1'b1, START = 1'b0, CONT = 1'b0;
  logic             CMP_RDY = 1'b0, CMP_OUT = 1'b0;
  logic             SMPL, CMP_EN, DONE, BUSY, TMO;
  logic [NBITS-1:0] DAC, DOUT;

  sun_sar_ctrl #(.NBITS(NBITS), .NSAMP(NSAMP), .NSET(NSET), .NTMO(NTMO)) dut (
    .CK(CK), .RST(RST), .START(START), .CONT(CONT), .CMP_RDY(CMP_RDY), .CMP_OUT(CMP_OUT),
    .SMPL(SMPL), .DAC(DAC), .CMP_EN(CMP_EN), .DOUT(DOUT), .DONE(DONE), .BUSY(BUSY), .TMO(TMO)
  );

  always #5 CK = ~CK;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_dones = 0;
  always @(posedge CK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- comparator model ----------------
  logic [7:0] mdl_target = 8'h00;
  int         mdl_k = 1, mdl_tmo_bit = -1, en_cnt = 0, cur_bit;
  bit         mdl_glitch = 1'b0;

  always @(negedge CK) begin
    if (RST) begin
      CMP_RDY = 1'b0; CMP_OUT = 1'b0; en_cnt = 0;
    end else if (CMP_EN) begin
      cur_bit = -1;  // bit under trial = lowest set DAC bit
      for (int b = NBITS - 1; b >= 0; b--) if (DAC[b]) cur_bit = b;
      CMP_OUT = (mdl_target >= DAC);
      CMP_RDY = (en_cnt == mdl_k) && (cur_bit != mdl_tmo_bit);
      en_cnt++;
    end else begin
      en_cnt  = 0;
      CMP_RDY = mdl_glitch && BUSY;
      CMP_OUT = 1'b0;
    end
  end

  // ---------------- scoreboard + protocol monitor ----------------
  typedef struct {logic [7:0] code; logic tmo; int lat; int start_cyc;} exp_t;
  exp_t       sbq[$];
  exp_t       e;
  logic [7:0] trials[$];
  logic       prev_smpl = 0, prev_cen = 0, done_seen = 0, cont_at_done = 0, had_cmp = 0;
  int         smpl_run = 0, low_run = 0;

  always @(negedge CK) begin
    if (RST) begin
      done_seen = 0; had_cmp = 0; smpl_run = 0; low_run = 0;
    end else begin
      if (done_seen) begin
        if (cont_at_done) chk("smpl_after_done", SMPL, 1);
        else              chk("idle_after_done", BUSY, 0);
      end
      done_seen    = DONE;
      cont_at_done = CONT;
      if (DONE) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: DOUT=%0h, no conversion pending", DOUT);
        end else begin
          e = sbq.pop_front();
          chk("dout", DOUT, e.code);
          chk("tmo", TMO, e.tmo);
          if (e.lat != 0) chk("latency", cyc - e.start_cyc, e.lat);
        end
      end
      if (SMPL && !prev_smpl) begin
        chk("tmo_clr_on_sample", TMO, 0);
        smpl_run = 0; had_cmp = 0;
      end
      if (SMPL) smpl_run++;
      if (!SMPL && prev_smpl) chk("smpl_width", smpl_run, NSAMP);
      if (CMP_EN && !prev_cen) begin
        trials.push_back(DAC);
        if (had_cmp) chk("cmp_en_gap", low_run, NSET);
      end
      if (CMP_EN) begin had_cmp = 1; low_run = 0; end
      else if (had_cmp) low_run++;
    end
    prev_smpl = SMPL;
    prev_cen  = CMP_EN;
  end

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_cnt < n && t < budget) begin @(posedge CK); t++; end
    chk("done_within_budget", (done_cnt >= n), 1);
  endtask

  task automatic push_exp(input logic [7:0] code, input logic tmo, input int lat);
    sbq.push_back('{code, tmo, lat, cyc});
    exp_dones++;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] target; int k; int tmo_bit; bit glitch; bit busy_start;
    logic [7:0] code; logic tmo; int lat; bit chk_trials;
  } vec_t;
  vec_t       tbl[7];
  logic [7:0] exp_tr[8];
  logic       found;

  initial begin
    tbl[0] = '{8'hA5, 1, -1, 1'b0, 1'b1, 8'hA5, 1'b0, 29, 1'b1};
    tbl[1] = '{8'h00, 1, -1, 1'b0, 1'b0, 8'h00, 1'b0, 29, 1'b0};
    tbl[2] = '{8'hFF, 1, -1, 1'b0, 1'b1, 8'hFF, 1'b0, 29, 1'b0};
    tbl[3] = '{8'hFF, 1,  3, 1'b0, 1'b0, 8'hF7, 1'b1, 34, 1'b0};
    tbl[4] = '{8'h5A, 3, -1, 1'b1, 1'b0, 8'h5A, 1'b0, 45, 1'b0};
    tbl[5] = '{8'h81, 2, -1, 1'b0, 1'b0, 8'h81, 1'b0, 37, 1'b0};
    tbl[6] = '{8'h3B, 6, -1, 1'b0, 1'b0, 8'h3B, 1'b0, 69, 1'b0};
    exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    // reset state
    repeat (2) @(posedge CK);
    #1;
    chk("rst_smpl", SMPL, 0); chk("rst_dac", DAC, 0); chk("rst_cmp_en", CMP_EN, 0);
    chk("rst_dout", DOUT, 0); chk("rst_done", DONE, 0); chk("rst_busy", BUSY, 0);
    chk("rst_tmo", TMO, 0);
    @(negedge CK); RST = 1'b0;

    foreach (tbl[i]) begin
      mdl_target = tbl[i].target; mdl_k = tbl[i].k;
      mdl_tmo_bit = tbl[i].tmo_bit; mdl_glitch = tbl[i].glitch;
      trials.delete();
      @(posedge CK); #1 START = 1'b1;
      push_exp(tbl[i].code, tbl[i].tmo, tbl[i].lat);
      @(posedge CK); #1 START = 1'b0;
      if (tbl[i].busy_start) begin
        repeat (8) @(posedge CK);
        #1 START = 1'b1;
        @(posedge CK); #1 START = 1'b0;
      end
      wait_done(exp_dones, 200);
      repeat (4) @(posedge CK);
      #1;
      chk("idle_after_conv", BUSY, 0);
      chk("sb_drained", sbq.size(), 0);
      if (tbl[i].tmo) chk("tmo_sticky", TMO, 1);
      if (tbl[i].chk_trials) begin
        chk("n_trials", trials.size(), 8);
        for (int j = 0; j < 8; j++)
          if (j < trials.size()) chk("dac_trial", trials[j], exp_tr[j]);
      end
      mdl_glitch = 1'b0;
    end

    // reset during SETTLE of bit 5: abort at once, no DONE
    mdl_target = 8'hA5; mdl_k = 1; mdl_tmo_bit = -1;
    @(posedge CK); #1 START = 1'b1;
    @(posedge CK); #1 START = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(negedge CK);
      if (DAC == 8'hA0 && !CMP_EN && BUSY) found = 1'b1;
    end
    chk("reached_settle_bit5", found, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_smpl", SMPL, 0); chk("arst_dac", DAC, 0); chk("arst_cmp_en", CMP_EN, 0);
    chk("arst_dout", DOUT, 0); chk("arst_done", DONE, 0); chk("arst_busy", BUSY, 0);
    chk("arst_tmo", TMO, 0);
    @(posedge CK); @(negedge CK); RST = 1'b0;
    @(posedge CK); #1 START = 1'b1;
    push_exp(8'hA5, 1'b0, 29);
    @(posedge CK); #1 START = 1'b0;
    chk("start_after_reset", {BUSY, SMPL}, 2'b11);
    wait_done(exp_dones, 200);
    chk("done_count_after_reset", done_cnt, exp_dones);

    // continuous mode, START held high; drop CONT in the third conversion
    repeat (3) @(posedge CK);
    mdl_target = 8'h3C;
    @(posedge CK); #1 START = 1'b1; CONT = 1'b1;
    push_exp(8'h3C, 1'b0, 29);
    push_exp(8'h3C, 1'b0, 0);
    push_exp(8'h3C, 1'b0, 0);
    wait_done(exp_dones - 1, 300);
    repeat (10) @(posedge CK);
    #1 CONT = 1'b0; START = 1'b0;
    wait_done(exp_dones, 200);
    repeat (40) @(posedge CK);
    #1;
    chk("cont_stop_idle", BUSY, 0);
    chk("cont_sb_drained", sbq.size(), 0);
    chk("cont_done_count", done_cnt, exp_dones);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
